// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Bit period is captured from clk_per_bit at accept time; all outputs come straight from flops.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 10,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] clk_per_bit,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [DIV_WIDTH-1:0]   w_div_in;
    logic [IDX_W-1:0]       r_bit_idx;
    logic                   r_stop_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_tx_ready;
    logic                   r_busy;
    logic                   w_accept;
    logic                   w_adv;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_tx_nxt;
    logic                   w_ready_nxt;
    logic                   w_busy_nxt;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        parity_bit = (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    // A divisor of 0 behaves like 1: the counter reload value is N-1, clamped at 0.
    assign w_div_in    = (clk_per_bit == DIV_ZERO) ? DIV_ZERO : (clk_per_bit - DIV_WIDTH'(1'b1));
    assign w_accept    = (r_state == S_IDLE) && tx_valid && r_tx_ready;
    assign w_adv       = (r_cnt == DIV_ZERO);
    assign w_last_data = (r_bit_idx == LAST_IDX);
    assign w_last_stop = (STOP_BITS < 2) || r_stop_idx;

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
                else          w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (w_adv) w_state_nxt = S_DATA;
                else       w_state_nxt = S_START;
            end
            S_DATA: begin
                if (w_adv && w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                else                      w_state_nxt = S_DATA;
            end
            S_PARITY: begin
                if (w_adv) w_state_nxt = S_STOP;
                else       w_state_nxt = S_PARITY;
            end
            S_STOP: begin
                if (w_adv && w_last_stop) w_state_nxt = S_IDLE;
                else                      w_state_nxt = S_STOP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered line, ready and busy outputs
    always_comb begin
        w_tx_nxt = r_tx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_tx_nxt = 1'b0;
                else          w_tx_nxt = 1'b1;
            end
            S_START: begin
                if (w_adv) w_tx_nxt = r_shift[0];
                else       w_tx_nxt = r_tx;
            end
            S_DATA: begin
                if (w_adv && w_last_data) w_tx_nxt = (PARITY != 0) ? r_par : 1'b1;
                else if (w_adv)           w_tx_nxt = r_shift[1];
                else                      w_tx_nxt = r_tx;
            end
            S_PARITY: begin
                if (w_adv) w_tx_nxt = 1'b1;
                else       w_tx_nxt = r_tx;
            end
            S_STOP:  w_tx_nxt = 1'b1;
            default: w_tx_nxt = 1'b1;
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_tx       <= w_tx_nxt;
            r_tx_ready <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Bit-period counter, bit/stop indices and captured frame contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= DIV_ZERO;
            r_div      <= DIV_ZERO;
            r_bit_idx  <= {IDX_W{1'b0}};
            r_stop_idx <= 1'b0;
            r_shift    <= {DATA_BITS{1'b0}};
            r_par      <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= w_div_in;
            r_div      <= w_div_in;
            r_bit_idx  <= {IDX_W{1'b0}};
            r_stop_idx <= 1'b0;
            r_shift    <= tx_data;
            r_par      <= parity_bit(tx_data);
        end else if (r_state != S_IDLE) begin
            if (w_adv) begin
                r_cnt <= r_div;
                if (r_state == S_DATA) begin
                    r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                    r_bit_idx <= r_bit_idx + IDX_W'(1'b1);
                end else if (r_state == S_STOP) begin
                    r_stop_idx <= ~r_stop_idx;
                end else begin
                    r_bit_idx <= r_bit_idx;
                end
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1'b1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter variants share clock, reset and divisor input.
module tb_uart_tx_param;

    logic       clk;
    logic       rst;
    logic [9:0] cpb;
    logic       v0, v1, v2, v3;
    logic [7:0] d0, d3;
    logic [6:0] d1, d2;
    logic       tx0, tx1, tx2, tx3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       busy0, busy1, busy2, busy3;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    logic m_tx, m_rdy, m_busy;
    logic [0:127] rec_tx, rec_rdy, rec_busy;
    logic [0:127] exp_tx, exp_rdy;

    uart_tx_param dut0 (
        .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(d0), .tx_valid(v0),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0)
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(d1), .tx_valid(v1),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1)
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(d2), .tx_valid(v2),
        .tx_ready(rdy2), .tx(tx2), .busy(busy2)
    );
    uart_tx_param #(.STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .clk_per_bit(cpb), .tx_data(d3), .tx_valid(v3),
        .tx_ready(rdy3), .tx(tx3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        case (sel)
            1:       begin m_tx = tx1; m_rdy = rdy1; m_busy = busy1; end
            2:       begin m_tx = tx2; m_rdy = rdy2; m_busy = busy2; end
            3:       begin m_tx = tx3; m_rdy = rdy3; m_busy = busy3; end
            default: begin m_tx = tx0; m_rdy = rdy0; m_busy = busy0; end
        endcase
    end

    // Frame bits (index 0 = start bit) stretched to n cycles each; idle-high afterwards.
    function automatic logic [0:127] expand(input logic [0:15] bits, input int n);
        for (int i = 0; i < 128; i++) begin
            if (i / n < 16) expand[i] = bits[i / n];
            else            expand[i] = 1'b1;
        end
    endfunction

    function automatic logic [0:127] ready_after(input int len);
        for (int i = 0; i < 128; i++) ready_after[i] = (i >= len);
    endfunction

    task automatic clear_rec();
        rec_tx   = '1;
        rec_rdy  = '1;
        rec_busy = '0;
    endtask

    task automatic record(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            rec_tx[i]   = m_tx;
            rec_rdy[i]  = m_rdy;
            rec_busy[i] = m_busy;
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at accept edge + 1, i.e. inside the first start-bit cycle.
    task automatic send(input int s, input logic [7:0] d, input logic [9:0] c, input bit hold);
        @(negedge clk);
        sel = s;
        cpb = c;
        case (s)
            1:       begin d1 = d[6:0]; v1 = 1'b1; end
            2:       begin d2 = d[6:0]; v2 = 1'b1; end
            3:       begin d3 = d;      v3 = 1'b1; end
            default: begin d0 = d;      v0 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if (!hold) begin
            v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({tx0, tx1, tx2, tx3} !== 4'b1111) begin
            bad++; $display("FAIL reset_tx got=%b want=1111", {tx0, tx1, tx2, tx3});
        end
        total++;
        if ({rdy0, rdy1, rdy2, rdy3} !== 4'b1111) begin
            bad++; $display("FAIL reset_ready got=%b want=1111", {rdy0, rdy1, rdy2, rdy3});
        end
        total++;
        if ({busy0, busy1, busy2, busy3} !== 4'b0000) begin
            bad++; $display("FAIL reset_busy got=%b want=0000", {busy0, busy1, busy2, busy3});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_frame();
        clear_rec();
        send(0, 8'hA5, 10'd4, 1'b0);
        record(0, 44);
        exp_tx  = expand(16'b0101001011_111111, 4);
        exp_rdy = ready_after(40);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL default_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL default_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
        total++;
        if (rec_busy[0:44] !== ~exp_rdy[0:44]) begin
            bad++; $display("FAIL default_busy got=%h want=%h", rec_busy[0:44], ~exp_rdy[0:44]);
        end
    endtask

    task automatic test_parity();
        clear_rec();
        send(1, 8'h07, 10'd2, 1'b0);
        record(0, 22);
        exp_tx  = expand(16'b0111000011_111111, 2);
        exp_rdy = ready_after(20);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL even_parity_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL even_parity_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
        clear_rec();
        send(2, 8'h07, 10'd2, 1'b0);
        record(0, 22);
        exp_tx = expand(16'b0111000001_111111, 2);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL odd_parity_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL odd_parity_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
    endtask

    task automatic test_min_divisor();
        logic [9:0] divs [2];
        divs[0] = 10'd0;
        divs[1] = 10'd1;
        for (int k = 0; k < 2; k++) begin
            clear_rec();
            send(0, 8'h55, divs[k], 1'b0);
            record(0, 12);
            exp_tx  = expand(16'b0101010101_111111, 1);
            exp_rdy = ready_after(10);
            total++;
            if (rec_tx !== exp_tx) begin
                bad++; $display("FAIL min_div_tx cpb=%0d got=%h want=%h", divs[k], rec_tx, exp_tx);
            end
            total++;
            if (rec_rdy !== exp_rdy) begin
                bad++; $display("FAIL min_div_ready cpb=%0d got=%h want=%h", divs[k], rec_rdy, exp_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] f1, f2;
        f1 = expand(16'b0100000001_111111, 3);
        f2 = expand(16'b0010000001_111111, 3);
        for (int i = 0; i < 128; i++) begin
            if (i < 30)       exp_tx[i] = f1[i];
            else if (i == 30) exp_tx[i] = 1'b1;
            else if (i <= 60) exp_tx[i] = f2[i - 31];
            else              exp_tx[i] = 1'b1;
            exp_rdy[i] = (i == 30) || (i >= 61);
        end
        clear_rec();
        send(0, 8'h01, 10'd3, 1'b1);
        record(0, 14);
        d0  = 8'h02;
        cpb = 10'd7;
        record(15, 24);
        cpb = 10'd3;
        record(25, 44);
        v0 = 1'b0;
        record(45, 64);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL b2b_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL b2b_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_rec();
        send(0, 8'h33, 10'd4, 1'b0);
        record(0, 17);
        total++;
        if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++; $display("FAIL mid_frame_bit3 got tx=%b busy=%b want tx=0 busy=1", tx0, busy0);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({tx0, busy0, rdy0} !== 3'b101) begin
            bad++; $display("FAIL async_abort got tx,busy,ready=%b want=101", {tx0, busy0, rdy0});
        end
        @(negedge clk);
        d0 = 8'hFF;
        v0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        clear_rec();
        record(0, 42);
        exp_tx  = expand(16'b0111111111_111111, 4);
        exp_rdy = ready_after(40);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL post_reset_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL post_reset_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
    endtask

    task automatic test_two_stop_bits();
        clear_rec();
        send(3, 8'h00, 10'd5, 1'b0);
        record(0, 58);
        exp_tx  = expand(16'b0000000001_111111, 5);
        exp_rdy = ready_after(55);
        total++;
        if (rec_tx !== exp_tx) begin
            bad++; $display("FAIL stop2_tx got=%h want=%h", rec_tx, exp_tx);
        end
        total++;
        if (rec_rdy !== exp_rdy) begin
            bad++; $display("FAIL stop2_ready got=%h want=%h", rec_rdy, exp_rdy);
        end
        total++;
        if (rec_busy[0:58] !== ~exp_rdy[0:58]) begin
            bad++; $display("FAIL stop2_busy got=%h want=%h", rec_busy[0:58], ~exp_rdy[0:58]);
        end
    endtask

    initial begin
        rst = 1'b1;
        cpb = 10'd4;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        d0 = 8'h00; d1 = 7'h00; d2 = 7'h00; d3 = 8'h00;
        test_reset();
        test_default_frame();
        test_parity();
        test_min_divisor();
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop_bits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_WIDTH, default 10, width of the clocks-per-bit divisor.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clk_per_bit  input  DIV_WIDTH  clock cycles per serial bit.
REQ-008 SHALL have port tx_data  input  DATA_BITS  byte/word to send, LSB first.
REQ-009 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-010 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress.

Function
REQ-013 SHALL accept a word on the rising edge where tx_valid && tx_ready; tx_data and clk_per_bit are captured on that edge and held for the whole frame.
REQ-014 SHALL drive tx_ready = 1 only in IDLE; tx_ready is registered and deasserts on the accept edge.
REQ-015 SHALL use FSM states IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
REQ-016 SHALL begin the start bit (tx = 0) on the cycle after the accept edge; no idle gap cycle.
REQ-017 SHALL hold each bit for exactly N cycles, N = captured clk_per_bit; a captured value of 0 SHALL be treated as N = 1.
REQ-018 SHALL use a bit-period down-counter of DIV_WIDTH bits loaded with N-1 at each bit start and advance the bit at count 0; no wrap-around beyond one period.
REQ-019 SHALL send DATA_BITS data bits LSB first, tracked by a bit index counter of clog2(DATA_BITS) bits.
REQ-020 SHALL send the parity bit as XOR of data bits (even, PARITY=1) or its inverse (odd, PARITY=2).
REQ-021 SHALL send STOP_BITS stop bits of 1, each N cycles, then return to IDLE with tx_ready = 1 on the cycle after the last stop-bit cycle.
REQ-022 SHALL drive tx from a register (glitch-free) and hold tx = 1 in IDLE.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL ignore tx_valid and changes on tx_data/clk_per_bit while busy; no queuing.
REQ-025 SHALL, when tx_valid is held high continuously, send back-to-back frames with the next start bit immediately after the IDLE cycle (exactly one idle cycle between frames).
REQ-026 Total frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * N cycles from first start-bit cycle to last stop-bit cycle.

Reset
REQ-027 SHALL on rst = 1, asynchronously and regardless of state: FSM to IDLE, tx = 1, tx_ready = 1, busy = 0, counters and captured registers to 0.
REQ-028 SHALL, when reset asserts mid-frame, abort the frame with tx returning to 1 immediately; no partial frame resumes after release.
REQ-029 SHALL accept a new word on the first rising edge after rst deasserts if tx_valid = 1.

Verification
REQ-030 Defaults, clk_per_bit=4, send 0xA5 -> tx: 4 cycles 0, bits 1,0,1,0,0,1,0,1 each 4 cycles, 4 cycles 1; frame = 40 cycles; tx_ready low throughout.
REQ-031 PARITY=1, DATA_BITS=7, clk_per_bit=2, send 0x07 -> parity bit 1; PARITY=2 same word -> parity bit 0; frame = 20 cycles.
REQ-032 clk_per_bit=0 and clk_per_bit=1, send 0x55 -> both produce 1 cycle per bit, 10-cycle frame, alternating 0/1 pattern after start.
REQ-033 tx_valid held high, 0x01 then 0x02, clk_per_bit=3 -> two 30-cycle frames separated by exactly one idle cycle; clk_per_bit changed to 7 mid-frame has no effect on the current frame.
REQ-034 Assert rst during data bit 3 of a frame -> tx = 1, busy = 0, tx_ready = 1 without a clock edge; after release, new word 0xFF sent correctly.
REQ-035 STOP_BITS=2, clk_per_bit=5, send 0x00 -> 10 cycles of stop (tx = 1) before tx_ready reasserts; total frame 55 cycles.
